alu_exec_unit: RTL and testbench
================================

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits (>=4, power of 2).
REQ-002 Parameter FUNC_W, default 4: width of the function field.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operation request valid.
REQ-006 in_ready  output  1  unit can accept a request.
REQ-007 alu_op  input  2  operation class: 11 add, 01 sub, 10 slt, 00 decode via function.
REQ-008 function  input  FUNC_W  operation code, used only when alu_op=00.
REQ-009 a, b  input  WIDTH each  operands.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 result  output  WIDTH  operation result.
REQ-013 zero  output  1  high when result is all zeros.

Function
REQ-014 Decode with alu_op=00 SHALL be: function 0 add, 1 sub, 2 and, 3 or, 4 slt, 5 sll, 6 mul; any other code, including 6 without MUL_EN, SHALL execute add.
REQ-015 Add and sub SHALL wrap modulo 2^WIDTH, with no overflow flag.
REQ-016 slt SHALL compare signed (two's complement) and return 1 when a<b, else 0, zero-extended to WIDTH.
REQ-017 sll SHALL shift a left by b[log2(WIDTH)-1:0], one bit per cycle; the upper bits of b are ignored.
REQ-018 mul SHALL be a shift-add over WIDTH cycles and return the low WIDTH bits of a*b (unsigned).
REQ-019 The FSM SHALL have states IDLE, SHIFT, MUL and DONE.
REQ-020 in_ready SHALL be 1 only in IDLE; a request is accepted on a clk edge with in_valid=1 and in_ready=1.
REQ-021 On acceptance, operands and the decoded operation SHALL be registered, and later input changes SHALL be ignored.
REQ-022 add/sub/and/or/slt, and sll with shift amount 0: IDLE->DONE, out_valid=1 on the cycle after acceptance (latency 1).
REQ-023 sll with shift amount N>0: IDLE->SHIFT, N cycles in SHIFT, then DONE; latency N+1.
REQ-024 mul: IDLE->MUL, WIDTH cycles in MUL, then DONE; latency WIDTH+1.
REQ-025 In DONE, out_valid=1 and result/zero SHALL hold stable until out_ready=1; on that edge go to IDLE with out_valid=0.
REQ-026 out_ready SHALL be ignored when out_valid=0; in_valid SHALL be ignored outside IDLE, with no queuing.
REQ-027 Back-to-back throughput for single-cycle ops SHALL be one result per 2 cycles.
REQ-028 zero SHALL be derived from the registered result, never from a partial value.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, in_ready=1, out_valid=0, result=0, zero=1, and clear the internal counters.
REQ-030 Reset mid-operation (SHIFT/MUL/DONE) SHALL abandon the operation; no result is delivered after release.
REQ-031 After rst_n release, the first clk edge SHALL be able to accept a request.

Configuration
REQ-032 Macro ALU_EXEC_MUL_EN: when defined, the MUL state and multiplier datapath SHALL be compiled in and function 6 executes mul.
REQ-033 Without ALU_EXEC_MUL_EN: there is no MUL state or multiplier logic, function 6 executes add, and all other behaviour is identical.

Verification
REQ-034 WIDTH=32, alu_op=11, a=0xFFFFFFFF, b=1 -> out_valid 1 cycle after accept, result=0, zero=1.
REQ-035 alu_op=10, a=0xFFFFFFFE (-2), b=3 -> result=1; then a=3, b=0xFFFFFFFE -> result=0.
REQ-036 alu_op=00, function=5, a=0x1, b=0x25 (shift amount 5) -> out_valid 6 cycles after accept, result=0x20; in_ready=0 throughout.
REQ-037 With ALU_EXEC_MUL_EN: function=6, a=7, b=6 -> result=42 after 33 cycles; without the macro -> result=13 after 1 cycle.
REQ-038 out_ready held 0 for 5 cycles in DONE -> result stable and in_valid ignored; out_ready=1 -> IDLE on the next edge.
REQ-039 rst_n pulsed low during cycle 10 of a mul -> immediately out_valid=0, in_ready=1; no stale out_valid afterwards.

Source files
------------

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: single-issue ALU with a valid/ready handshake on both sides.
// Single-cycle ops (add/sub/and/or/slt) plus a bit-serial left shift and an
// optional bit-serial shift-add multiplier enabled by macro ALU_EXEC_MUL_EN.
// The operation-code input is named func because "function" is a reserved word.
module alu_exec_unit #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned FUNC_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        alu_op,
  input  logic [FUNC_W-1:0] func,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  result,
  output logic              zero
);

  localparam int unsigned SH_W  = $clog2(WIDTH);
  localparam int unsigned CNT_W = SH_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
`ifdef ALU_EXEC_MUL_EN
    MUL   = 2'd2,
`endif
    DONE  = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_SLT = 3'd4,
`ifdef ALU_EXEC_MUL_EN
    OP_MUL = 3'd6,
`endif
    OP_SLL = 3'd5
  } op_e;

  state_e             state, state_nxt;
  op_e                op_dec;
  logic [WIDTH-1:0]   alu_res;
  logic [WIDTH-1:0]   acc, acc_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [WIDTH-1:0]   result_nxt;
  logic [SH_W-1:0]    shamt;
`ifdef ALU_EXEC_MUL_EN
  logic [WIDTH-1:0]   mul_a, mul_a_nxt;
  logic [WIDTH-1:0]   mul_b, mul_b_nxt;
  logic [WIDTH-1:0]   mul_sum;
`endif

  assign shamt = b[SH_W-1:0];

  // Decode alu_op/func into an operation and compute the single-cycle result.
  always_comb begin
    op_dec = OP_ADD;
    case (alu_op)
      2'b11: op_dec = OP_ADD;
      2'b01: op_dec = OP_SUB;
      2'b10: op_dec = OP_SLT;
      default: begin
        case (func)
          FUNC_W'(0): op_dec = OP_ADD;
          FUNC_W'(1): op_dec = OP_SUB;
          FUNC_W'(2): op_dec = OP_AND;
          FUNC_W'(3): op_dec = OP_OR;
          FUNC_W'(4): op_dec = OP_SLT;
          FUNC_W'(5): op_dec = OP_SLL;
`ifdef ALU_EXEC_MUL_EN
          FUNC_W'(6): op_dec = OP_MUL;
`endif
          default:    op_dec = OP_ADD;
        endcase
      end
    endcase

    alu_res = a + b;
    case (op_dec)
      OP_SUB:  alu_res = a - b;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_SLT:  alu_res = WIDTH'($signed(a) < $signed(b));
      default: alu_res = a + b;
    endcase
  end

  // Next-state and datapath update for the operation FSM.
  always_comb begin
    state_nxt  = state;
    acc_nxt    = acc;
    cnt_nxt    = cnt;
    result_nxt = result;
`ifdef ALU_EXEC_MUL_EN
    mul_a_nxt  = mul_a;
    mul_b_nxt  = mul_b;
    mul_sum    = mul_a[0] ? (acc + mul_b) : acc;
`endif
    case (state)
      IDLE: begin
        if (in_valid) begin
          case (op_dec)
            OP_SLL: begin
              if (shamt == '0) begin
                result_nxt = a;
                state_nxt  = DONE;
              end else begin
                acc_nxt   = a;
                cnt_nxt   = CNT_W'(shamt);
                state_nxt = SHIFT;
              end
            end
`ifdef ALU_EXEC_MUL_EN
            OP_MUL: begin
              acc_nxt   = '0;
              mul_a_nxt = a;
              mul_b_nxt = b;
              cnt_nxt   = CNT_W'(WIDTH);
              state_nxt = MUL;
            end
`endif
            default: begin
              result_nxt = alu_res;
              state_nxt  = DONE;
            end
          endcase
        end
      end
      SHIFT: begin
        acc_nxt = acc << 1;
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          result_nxt = acc << 1;
          state_nxt  = DONE;
        end
      end
`ifdef ALU_EXEC_MUL_EN
      MUL: begin
        acc_nxt   = mul_sum;
        mul_a_nxt = mul_a >> 1;
        mul_b_nxt = mul_b << 1;
        cnt_nxt   = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          result_nxt = mul_sum;
          state_nxt  = DONE;
        end
      end
`endif
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, datapath and registered outputs; zero tracks the committed result only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      result    <= '0;
      zero      <= 1'b1;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
`ifdef ALU_EXEC_MUL_EN
      mul_a     <= '0;
      mul_b     <= '0;
`endif
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      cnt       <= cnt_nxt;
      result    <= result_nxt;
      zero      <= (result_nxt == '0);
      in_ready  <= (state_nxt == IDLE);
      out_valid <= (state_nxt == DONE);
`ifdef ALU_EXEC_MUL_EN
      mul_a     <= mul_a_nxt;
      mul_b     <= mul_b_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed testbench for alu_exec_unit (WIDTH=32); follows ALU_EXEC_MUL_EN.
`timescale 1ns/1ps
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  alu_op;
  logic [3:0]  func;
  logic [31:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;

  int total = 0;
  int bad   = 0;

  alu_exec_unit #(.WIDTH(32), .FUNC_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .func(func), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .zero(zero)
  );

  always #5 clk = ~clk;

  // Issue one request, scramble the inputs after acceptance, wait for out_valid.
  task automatic issue(input logic [1:0] op, input logic [3:0] fn,
                       input logic [31:0] xa, input logic [31:0] xb,
                       output logic [31:0] res, output logic z,
                       output int lat, output logic rdy_seen);
    @(negedge clk);
    alu_op = op; func = fn; a = xa; b = xb; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; alu_op = 2'b00; func = 4'd6; a = 32'hDEAD_BEEF; b = 32'h1234_5678;
    lat = 1; rdy_seen = 1'b0;
    while (!out_valid && lat < 100) begin
      if (in_ready) rdy_seen = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    if (in_ready) rdy_seen = 1'b1;
    res = result; z = zero;
  endtask

  // Take the pending result.
  task automatic consume();
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; alu_op = 2'b11; func = 4'd0; a = '0; b = '0;
    #12;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (result !== 32'h0 || zero !== 1'b1) begin bad++; $display("FAIL reset_result got=%h/%b exp=0/1", result, zero); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_add_sub();
    logic [31:0] r; logic z; int lat; logic rs;
    issue(2'b11, 4'd0, 32'hFFFF_FFFF, 32'h1, r, z, lat, rs);
    total++; if (r !== 32'h0 || z !== 1'b1 || lat != 1) begin bad++; $display("FAIL add_wrap got=%h z=%b lat=%0d exp=0 z=1 lat=1", r, z, lat); end
    consume();
    issue(2'b00, 4'd0, 32'd5, 32'd7, r, z, lat, rs);
    total++; if (r !== 32'd12 || z !== 1'b0) begin bad++; $display("FAIL add_func got=%h z=%b exp=c z=0", r, z); end
    consume();
    issue(2'b01, 4'd9, 32'd3, 32'd5, r, z, lat, rs);
    total++; if (r !== 32'hFFFF_FFFE || lat != 1) begin bad++; $display("FAIL sub_wrap got=%h lat=%0d exp=fffffffe lat=1", r, lat); end
    consume();
    issue(2'b00, 4'd1, 32'd10, 32'd3, r, z, lat, rs);
    total++; if (r !== 32'd7) begin bad++; $display("FAIL sub_func got=%h exp=7", r); end
    consume();
  endtask

  task automatic test_slt_logic();
    logic [31:0] r; logic z; int lat; logic rs;
    issue(2'b10, 4'd0, 32'hFFFF_FFFE, 32'd3, r, z, lat, rs);
    total++; if (r !== 32'd1 || z !== 1'b0) begin bad++; $display("FAIL slt_neg_lt got=%h z=%b exp=1 z=0", r, z); end
    consume();
    issue(2'b10, 4'd0, 32'd3, 32'hFFFF_FFFE, r, z, lat, rs);
    total++; if (r !== 32'd0 || z !== 1'b1) begin bad++; $display("FAIL slt_pos_ge got=%h z=%b exp=0 z=1", r, z); end
    consume();
    issue(2'b00, 4'd4, 32'd9, 32'd9, r, z, lat, rs);
    total++; if (r !== 32'd0) begin bad++; $display("FAIL slt_equal got=%h exp=0", r); end
    consume();
    issue(2'b00, 4'd2, 32'h0000_F0F0, 32'h0000_FF00, r, z, lat, rs);
    total++; if (r !== 32'h0000_F000) begin bad++; $display("FAIL and got=%h exp=f000", r); end
    consume();
    issue(2'b00, 4'd3, 32'h0000_F0F0, 32'h0000_FF00, r, z, lat, rs);
    total++; if (r !== 32'h0000_FFF0) begin bad++; $display("FAIL or got=%h exp=fff0", r); end
    consume();
    issue(2'b00, 4'd15, 32'd2, 32'd3, r, z, lat, rs);
    total++; if (r !== 32'd5 || lat != 1) begin bad++; $display("FAIL undef_func_add got=%h lat=%0d exp=5 lat=1", r, lat); end
    consume();
  endtask

  task automatic test_sll();
    logic [31:0] r; logic z; int lat; logic rs;
    issue(2'b00, 4'd5, 32'h1, 32'h25, r, z, lat, rs);
    total++; if (r !== 32'h20 || lat != 6) begin bad++; $display("FAIL sll5 got=%h lat=%0d exp=20 lat=6", r, lat); end
    total++; if (rs !== 1'b0) begin bad++; $display("FAIL sll5_in_ready got=%b exp=0", rs); end
    consume();
    issue(2'b00, 4'd5, 32'hABCD_0123, 32'h20, r, z, lat, rs);
    total++; if (r !== 32'hABCD_0123 || lat != 1) begin bad++; $display("FAIL sll0 got=%h lat=%0d exp=abcd0123 lat=1", r, lat); end
    consume();
    issue(2'b00, 4'd5, 32'h3, 32'h1F, r, z, lat, rs);
    total++; if (r !== 32'h8000_0000 || lat != 32) begin bad++; $display("FAIL sll31 got=%h lat=%0d exp=80000000 lat=32", r, lat); end
    consume();
  endtask

  task automatic test_func6();
    logic [31:0] r; logic z; int lat; logic rs;
    issue(2'b00, 4'd6, 32'd7, 32'd6, r, z, lat, rs);
`ifdef ALU_EXEC_MUL_EN
    total++; if (r !== 32'd42 || lat != 33) begin bad++; $display("FAIL mul got=%0d lat=%0d exp=42 lat=33", r, lat); end
    consume();
    issue(2'b00, 4'd6, 32'h0001_0001, 32'hFFFF_0003, r, z, lat, rs);
    total++; if (r !== 32'h0002_0003) begin bad++; $display("FAIL mul_trunc got=%h exp=20003", r); end
`else
    total++; if (r !== 32'd13 || lat != 1) begin bad++; $display("FAIL func6_add got=%0d lat=%0d exp=13 lat=1", r, lat); end
`endif
    consume();
  endtask

  task automatic test_hold();
    logic [31:0] r; logic z; int lat; logic rs; logic stable;
    issue(2'b11, 4'd0, 32'h10, 32'h20, r, z, lat, rs);
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); in_valid = 1'b1; alu_op = 2'b11; a = 32'd1; b = 32'd1;
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 32'h30 || zero !== 1'b0) stable = 1'b0;
    end
    total++; if (stable !== 1'b1) begin bad++; $display("FAIL hold_stable got=%b exp=1", stable); end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0; out_ready = 1'b0;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL hold_release got=%b/%b exp=0/1", out_valid, in_ready); end
    repeat (3) @(posedge clk); #1;
    total++; if (out_valid !== 1'b0 || result !== 32'h30) begin bad++; $display("FAIL hold_no_queue got=%b/%h exp=0/30", out_valid, result); end
  endtask

  task automatic test_back_to_back();
    int n; logic ok;
    n = 0; ok = 1'b1;
    @(negedge clk); alu_op = 2'b11; a = 32'd4; b = 32'd5; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin n++; if (result !== 32'd9) ok = 1'b0; end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    total++; if (n != 5 || ok !== 1'b1) begin bad++; $display("FAIL back_to_back got=%0d ok=%b exp=5 ok=1", n, ok); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r; logic z; int lat; logic rs; logic stale;
    @(negedge clk);
`ifdef ALU_EXEC_MUL_EN
    alu_op = 2'b00; func = 4'd6; a = 32'd7; b = 32'd6;
`else
    alu_op = 2'b00; func = 4'd5; a = 32'd1; b = 32'd31;
`endif
    in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_flags got=%b/%b exp=0/1", out_valid, in_ready); end
    total++; if (result !== 32'h0 || zero !== 1'b1) begin bad++; $display("FAIL rst_mid_result got=%h/%b exp=0/1", result, zero); end
    @(negedge clk); rst_n = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) stale = 1'b1;
    end
    total++; if (stale !== 1'b0) begin bad++; $display("FAIL rst_mid_stale got=%b exp=0", stale); end
    issue(2'b11, 4'd0, 32'd100, 32'd23, r, z, lat, rs);
    total++; if (r !== 32'd123 || lat != 1) begin bad++; $display("FAIL rst_after_op got=%0d lat=%0d exp=123 lat=1", r, lat); end
    consume();
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_slt_logic();
    test_sll();
    test_func6();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
